// File: rtl/gate_test_pkg.sv
// Shared definitions for two-input gate self-test: function codes, FSM states
// and the expected truth table for each supported cell.
package gate_test_pkg;

   localparam logic [2:0] FN_NAND = 3'd0;
   localparam logic [2:0] FN_NOR  = 3'd1;
   localparam logic [2:0] FN_AND  = 3'd2;
   localparam logic [2:0] FN_OR   = 3'd3;
   localparam logic [2:0] FN_XOR  = 3'd4;
   localparam logic [2:0] FN_XNOR = 3'd5;
   localparam logic [2:0] FN_LAST = 3'd5;

   localparam int unsigned NUM_FN = 6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Bit n of each entry is the expected output for input vector {a,b} == n.
   localparam logic [3:0] TRUTH_TABLE [NUM_FN] = '{
      4'b0111,  // NAND
      4'b0001,  // NOR
      4'b1000,  // AND
      4'b1110,  // OR
      4'b0110,  // XOR
      4'b1001   // XNOR
   };

   function automatic logic expected_y(input logic [2:0] fn, input logic [1:0] vec);
      logic y;
      if (fn <= FN_LAST) begin
         y = TRUTH_TABLE[fn][vec];
      end else begin
         y = 1'b0;
      end
      return y;
   endfunction

endpackage

// File: rtl/gate_expect.sv
// Combinational truth-table lookup: expected output of the selected 2-input cell.
// Illegal function codes yield 0.
module gate_expect
   import gate_test_pkg::*;
(
   input  logic [2:0] func_sel_i,
   input  logic       a_i,
   input  logic       b_i,
   output logic       y_o
);

   // Table lookup for the selected function and input vector
   always_comb begin
      y_o = expected_y(func_sel_i, {a_i, b_i});
   end

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Sequencer that drives all four input vectors into a 2-input gate, checks each
// settled output against the selected truth table and reports pass/fail.
module gate_selftest_ctrl
   import gate_test_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] func_sel,
   input  logic       gate_y,
   output logic       gate_a,
   output logic       gate_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic       first_fail_valid,
   output logic [1:0] first_fail_vec,
   output logic       cfg_err
);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || CNT_W < 1 || CNT_W > 31 ||
       SETTLE_CYCLES > (1 << CNT_W)) begin : g_bad_settle
      $error("gate_selftest_ctrl: SETTLE_CYCLES must be 1..255 and fit in CNT_W bits");
   end

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [2:0]       func_q, func_d;
   logic [1:0]       vec_q, vec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       err_q, err_d;
   logic             ffv_q, ffv_d;
   logic [1:0]       ffvec_q, ffvec_d;
   logic             pass_q, pass_d;
   logic             done_q, done_d;
   logic             cfg_err_q, cfg_err_d;
   logic             busy_q, busy_d;
   logic [1:0]       gate_q, gate_d;
   logic             exp_y_s;
   logic             mismatch_s;

   gate_expect u_expect (
      .func_sel_i (func_q),
      .a_i        (vec_q[1]),
      .b_i        (vec_q[0]),
      .y_o        (exp_y_s)
   );

   // X or Z on the gate output must never be taken as a correct level.
   assign mismatch_s = (gate_y !== exp_y_s);

   // Next-state, result update and registered-output decode
   always_comb begin
      state_d   = state_q;
      func_d    = func_q;
      vec_d     = vec_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      ffv_d     = ffv_q;
      ffvec_d   = ffvec_q;
      pass_d    = pass_q;
      cfg_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (func_sel <= FN_LAST) begin
                  func_d  = func_sel;
                  err_d   = 3'd0;
                  ffv_d   = 1'b0;
                  ffvec_d = 2'd0;
                  pass_d  = 1'b0;
                  vec_d   = 2'd0;
                  cnt_d   = '0;
                  state_d = ST_SETTLE;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_CHECK;
            end else begin
               state_d = ST_SETTLE;
            end
         end
         ST_CHECK: begin
            if (mismatch_s) begin
               err_d = err_q + 3'd1;
               if (!ffv_q) begin
                  ffv_d   = 1'b1;
                  ffvec_d = vec_q;
               end else begin
                  ffv_d = ffv_q;
               end
            end else begin
               err_d = err_q;
            end
            // pass is loaded on DONE entry so it is valid alongside done.
            if (vec_q == 2'd3) begin
               pass_d  = (err_d == 3'd0);
               state_d = ST_DONE;
            end else begin
               vec_d   = vec_q + 2'd1;
               cnt_d   = '0;
               state_d = ST_SETTLE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);
      if (state_d == ST_IDLE) begin
         gate_d = 2'b00;
      end else begin
         gate_d = vec_d;
      end
   end

   // State and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         func_q    <= 3'd0;
         vec_q     <= 2'd0;
         cnt_q     <= '0;
         err_q     <= 3'd0;
         ffv_q     <= 1'b0;
         ffvec_q   <= 2'd0;
         pass_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         busy_q    <= 1'b0;
         gate_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         func_q    <= func_d;
         vec_q     <= vec_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         ffv_q     <= ffv_d;
         ffvec_q   <= ffvec_d;
         pass_q    <= pass_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
         busy_q    <= busy_d;
         gate_q    <= gate_d;
      end
   end

   assign gate_a           = gate_q[1];
   assign gate_b           = gate_q[0];
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_vec   = ffvec_q;
   assign cfg_err          = cfg_err_q;

endmodule
